// File: rtl/crc_checker.sv
// Serial CRC-8 frame checker: payload bits update an LFSR, then 8 received CRC bits are compared LSB first.
// Optional saturating failed-frame counter on Err_Count when CRC_ERR_CNT_EN is defined.
module crc_checker (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Data,
  input  logic       Active,
  input  logic       CRC_In,
  input  logic       CRC_Valid,
  output logic       Check_Done,
  output logic       Check_Pass,
  output logic       Frame_Err
`ifdef CRC_ERR_CNT_EN
  ,
  output logic [7:0] Err_Count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC
  } state_e;

  localparam logic [7:0] SEED = 8'hD8;
  localparam logic [7:0] TAPS = 8'b0100_0100;

  state_e     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       mis_q, mis_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       ferr_q, ferr_d;
  logic       bit_mis;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l, input logic d);
    logic fb;
    fb = d ^ l[0];
    return {fb, l[7:1] ^ (TAPS[6:0] & {7{fb}})};
  endfunction

  assign bit_mis = CRC_In ^ lfsr_q[0];

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        lfsr_d = SEED;
        cnt_d  = 3'd0;
        mis_d  = 1'b0;
        if (Active) begin
          state_d = DATA;
          lfsr_d  = lfsr_step(SEED, Data);
        end
      end
      DATA: begin
        if (Active) begin
          lfsr_d = lfsr_step(lfsr_q, Data);
        end else if (CRC_Valid) begin
          mis_d   = bit_mis;
          lfsr_d  = {lfsr_q[7], lfsr_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          state_d = CRC;
        end
      end
      CRC: begin
        if (Active || !CRC_Valid) begin
          // Aborted frame: report and return to IDLE without starting a new frame.
          state_d = IDLE;
          done_d  = 1'b1;
          ferr_d  = 1'b1;
          pass_d  = 1'b0;
          lfsr_d  = SEED;
          cnt_d   = 3'd0;
          mis_d   = 1'b0;
        end else if (cnt_q == 3'd7) begin
          state_d = IDLE;
          done_d  = 1'b1;
          pass_d  = ~(mis_q | bit_mis);
          lfsr_d  = SEED;
          cnt_d   = 3'd0;
          mis_d   = 1'b0;
        end else begin
          mis_d  = mis_q | bit_mis;
          lfsr_d = {lfsr_q[7], lfsr_q[7:1]};
          cnt_d  = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= 3'd0;
      mis_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      ferr_q  <= ferr_d;
    end
  end

  assign Check_Done = done_q;
  assign Check_Pass = pass_q;
  assign Frame_Err  = ferr_q;

`ifdef CRC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts in the same edge as Check_Done so the new value is visible with the pulse.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (done_d && !pass_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) err_cnt_q <= 8'd0;
    else      err_cnt_q <= err_cnt_d;
  end

  assign Err_Count = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_checker.sv
// Self-checking bench for crc_checker: directed frames plus randomized frames against a CRC reference model.
module tb_crc_checker;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic Data = 1'b0;
  logic Active = 1'b0;
  logic CRC_In = 1'b0;
  logic CRC_Valid = 1'b0;
  logic Check_Done, Check_Pass, Frame_Err;
`ifdef CRC_ERR_CNT_EN
  logic [7:0] Err_Count;
`endif

  int   n_tests = 0;
  int   n_fail = 0;
  logic exp_pass = 1'b0;
  int   exp_err = 0;

  crc_checker dut (
    .CLK       (CLK),
    .RST       (RST),
    .Data      (Data),
    .Active    (Active),
    .CRC_In    (CRC_In),
    .CRC_Valid (CRC_Valid),
    .Check_Done(Check_Done),
    .Check_Pass(Check_Pass),
    .Frame_Err (Frame_Err)
`ifdef CRC_ERR_CNT_EN
    ,
    .Err_Count (Err_Count)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC of a payload as a polynomial-style register: shift right, xor 0xC4 on feedback.
  function automatic logic [7:0] ref_crc(input bit pl[$]);
    logic [7:0] r;
    r = 8'hD8;
    foreach (pl[i]) r = (pl[i] ^ r[0]) ? ((r >> 1) ^ 8'hC4) : (r >> 1);
    return r;
  endfunction

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic cycle(input logic a, input logic d, input logic v, input logic c);
    Active = a; Data = d; CRC_Valid = v; CRC_In = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " done"}, Check_Done, 1'b0);
    check({tag, " ferr"}, Frame_Err, 1'b0);
    check({tag, " pass_hold"}, Check_Pass, exp_pass);
  endtask

  task automatic check_end(input string tag, input logic pass, input logic ferr);
    exp_pass = pass;
    if (!pass && exp_err < 255) exp_err++;
    check({tag, " done"}, Check_Done, 1'b1);
    check({tag, " pass"}, Check_Pass, pass);
    check({tag, " ferr"}, Frame_Err, ferr);
`ifdef CRC_ERR_CNT_EN
    check({tag, " err_cnt"}, Err_Count, exp_err[7:0]);
`endif
  endtask

  // abort_kind: 0 none, 1 CRC_Valid drops before CRC bit abort_at, 2 Active on CRC bit abort_at.
  task automatic send_frame(input string tag, input bit pl[$], input logic [7:0] crc_bits,
                            input int pre_idle, input bit gaps, input int abort_kind,
                            input int abort_at);
    logic good;
    good = (crc_bits == ref_crc(pl));
    for (int i = 0; i < pre_idle; i++) begin
      cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      check_quiet({tag, " idle"});
    end
    foreach (pl[i]) begin
      if (gaps && i > 0 && ($urandom_range(3) == 0)) begin
        cycle(1'b0, 1'($urandom), 1'b0, 1'($urandom));
        check_quiet({tag, " gap"});
      end
      cycle(1'b1, pl[i], 1'($urandom), 1'($urandom));
      check_quiet({tag, " payload"});
    end
    for (int k = 0; k < 8; k++) begin
      if (abort_kind == 1 && k == abort_at) begin
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_end({tag, " vdrop"}, 1'b0, 1'b1);
        return;
      end
      if (abort_kind == 2 && k == abort_at) begin
        cycle(1'b1, 1'($urandom), 1'b1, 1'($urandom));
        check_end({tag, " act_abort"}, 1'b0, 1'b1);
        return;
      end
      cycle(1'b0, 1'b0, 1'b1, crc_bits[k]);
      if (k < 7) check_quiet({tag, " crc"});
      else       check_end(tag, good, 1'b0);
    end
  endtask

  task automatic idle_check(input string tag);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_quiet(tag);
  endtask

  bit q[$];

  initial begin
    RST = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst done", Check_Done, 1'b0);
    check("rst pass", Check_Pass, 1'b0);
    check("rst ferr", Frame_Err, 1'b0);
`ifdef CRC_ERR_CNT_EN
    check("rst err_cnt", Err_Count, 8'd0);
`endif
    RST = 1'b1;
    idle_check("post_rst");

    // Eight zeros: CRC 0x14, sent LSB first.
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(1'b0);
    send_frame("zeros8", q, 8'h14, 0, 1'b0, 0, 0);
    // Back-to-back: next frame starts in the cycle Check_Done is high.
    send_frame("zeros8_b2b", q, 8'h14, 0, 1'b0, 0, 0);
    idle_check("after_b2b");

    // Single payload bit 1: CRC 0xA8; then bit 3 flipped.
    q = {1'b1};
    send_frame("one_bit", q, 8'hA8, 1, 1'b0, 0, 0);
    idle_check("after_one_bit");
    send_frame("one_bit_bad", q, 8'hA0, 1, 1'b0, 0, 0);
    idle_check("after_one_bit_bad");

    // CRC_Valid drops after 5 CRC bits.
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(1'b0);
    send_frame("vdrop5", q, 8'h14, 0, 1'b0, 1, 5);
    idle_check("after_vdrop5");

    // Active reasserted on CRC bit 3, then a good frame must pass.
    send_frame("act3", q, 8'h14, 0, 1'b0, 2, 3);
    idle_check("after_act3");
    send_frame("good_after_act3", q, 8'h14, 0, 1'b0, 0, 0);
    idle_check("after_good");

    // Reset asserted on payload bit 4 discards the frame.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
      check_quiet("pre_rst_payload");
    end
    RST = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    exp_pass = 1'b0;
    exp_err  = 0;
    check("midrst done", Check_Done, 1'b0);
    check("midrst pass", Check_Pass, 1'b0);
    check("midrst ferr", Frame_Err, 1'b0);
`ifdef CRC_ERR_CNT_EN
    check("midrst err_cnt", Err_Count, 8'd0);
`endif
    RST = 1'b1;
    for (int i = 0; i < 10; i++) idle_check("post_midrst");
    send_frame("good_after_rst", q, 8'h14, 0, 1'b0, 0, 0);
    idle_check("after_rst_frame");

    // Randomized frames: random length, gaps, idle CRC_Valid noise and single-bit CRC errors.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] c;
      int         kind;
      q = {};
      for (int i = 0; i < int'($urandom_range(16, 1)); i++) q.push_back(1'($urandom));
      c = ref_crc(q);
      if ($urandom_range(2) == 0) c = c ^ (8'd1 << $urandom_range(7));
      kind = ($urandom_range(5) == 0) ? int'($urandom_range(2, 1)) : 0;
      send_frame($sformatf("rand%0d", n), q, c, int'($urandom_range(2)), 1'b1, kind,
                 int'($urandom_range(7, 1)));
      if ($urandom_range(1) == 0) idle_check("rand_tail");
    end
    idle_check("after_rand");

`ifdef CRC_ERR_CNT_EN
    // Saturation: 300 failing frames.
    q = {1'b1};
    for (int n = 0; n < 300; n++) send_frame("sat", q, 8'h00, 0, 1'b0, 0, 0);
    idle_check("after_sat");
    check("sat err_cnt", Err_Count, 8'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
